// File: rtl/mips_pkg.sv
// Shared MIPS datapath types, register-file defaults and ALU op encodings.
// Build option: REG_BYPASS_EN turns on write-through on the rs/rt read ports.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_OR   = 3'b010,
        ALU_AND  = 3'b011,
        ALU_NOR  = 3'b101,
        ALU_NOT  = 3'b110,
        ALU_HOLD = 3'b111
    } alu_op_t;

`ifdef REG_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/mips_reg_read_port.sv
// One combinational register-file read port: index mux, $0 force and
// optional same-cycle write-through from the write port.
module mips_reg_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter bit BYPASS = mips_pkg::BYPASS_EN
) (
    input  logic [ADDR_W-1:0]                   rd_addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic [DATA_W-1:0]                   rd_data
);

    always_comb begin
        rd_data = regs[rd_addr];
        if (BYPASS && wr_en && (wr_addr != '0) && (wr_addr == rd_addr))
            rd_data = wr_data;
        // $0 wins over both storage and bypass.
        if (rd_addr == '0)
            rd_data = '0;
    end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS register file: two combinational read ports (rs, rt), one write
// port, registered debug readout and a saturating write counter. Option: REG_BYPASS_EN.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int                DATA_W    = mips_pkg::DATA_W,
    parameter int                ADDR_W    = mips_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int NUM_PORTS = 2;

    logic [DEPTH-1:0][DATA_W-1:0]     regs;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
    logic                             wr_commit;

    assign wr_commit = wr_en && (wr_addr != '0);

    // Entry 0 is held at zero so the array never carries a stray value there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs[0] <= '0;
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= RESET_VAL;
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_count <= '0;
        else if (wr_commit && (wr_count != 16'hFFFF))
            wr_count <= wr_count + 16'd1;
    end

    // Samples storage before this edge's write lands, so it shows the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dbg_data <= '0;
        else
            dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

    assign rd_addr = {rt_addr, rs_addr};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_port
        mips_reg_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS_EN)
        ) u_rd_port (
            .rd_addr (rd_addr[p]),
            .regs    (regs),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[p])
        );
    end

    assign rs_data = rd_data[0];
    assign rt_data = rd_data[1];

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed self-checking bench for mips_reg_file, both REG_BYPASS_EN builds.
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic [31:0] rs_data, rt_data, wr_data, dbg_data;
    logic        wr_en;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left just after a negedge; write lands at the posedge between.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] exp7;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = 5'd1; rt_addr = 5'd31; dbg_addr = 5'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wr_count", {16'h0, wr_count}, 32'h0);
        chk("reset_dbg", dbg_data, 32'h0);
        rst = 1'b0;

        // 1: every index reads zero after reset
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            chk($sformatf("reset_rs[%0d]", i), rs_data, 32'h0);
            chk($sformatf("reset_rt[%0d]", 31 - i), rt_data, 32'h0);
        end
        @(negedge clk);
        chk("reset_wr_count_rel", {16'h0, wr_count}, 32'h0);

        // 2: write r5, read on both ports
        do_write(5'd5, 32'hDEADBEEF);
        rs_addr = 5'd5; rt_addr = 5'd5; #1;
        chk("r5_rs", rs_data, 32'hDEADBEEF);
        chk("r5_rt", rt_data, 32'hDEADBEEF);
        chk("r5_wr_count", {16'h0, wr_count}, 32'h1);

        // 3: write to r0 discarded, no bypass of index 0
        rs_addr = 5'd0; rt_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; #1;
        chk("r0_same_cycle", rs_data, 32'h0);
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0; #1;
        chk("r0_after_rs", rs_data, 32'h0);
        chk("r0_after_rt", rt_data, 32'h0);
        chk("r0_wr_count", {16'h0, wr_count}, 32'h1);

        // 4: same-cycle write/read of r7
        rs_addr = 5'd7; rt_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; #1;
`ifdef REG_BYPASS_EN
        exp7 = 32'h12345678;
`else
        exp7 = 32'h0;
`endif
        chk("r7_same_cycle_rs", rs_data, exp7);
        chk("r7_same_cycle_rt", rt_data, exp7);
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0; #1;
        chk("r7_after_edge", rs_data, 32'h12345678);

        // table of mixed reads after a few more writes
        do_write(5'd1,  32'h11111111);
        do_write(5'd2,  32'h80000001);
        do_write(5'd31, 32'hFFFFFFFF);
        do_write(5'd3,  32'h00000001);
        vecs[0] = '{5'd1,  5'd2,  32'h11111111, 32'h80000001};
        vecs[1] = '{5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
        vecs[2] = '{5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678};
        vecs[3] = '{5'd0,  5'd31, 32'h0,        32'hFFFFFFFF};
        vecs[4] = '{5'd3,  5'd3,  32'h00000001, 32'h00000001};
        vecs[5] = '{5'd2,  5'd1,  32'h80000001, 32'h11111111};
        vecs[6] = '{5'd6,  5'd30, 32'h0,        32'h0};
        vecs[7] = '{5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
        for (int i = 0; i < 8; i++) begin
            rs_addr = vecs[i].rs; rt_addr = vecs[i].rt; #1;
            chk($sformatf("vec%0d_rs", i), rs_data, vecs[i].exp_rs);
            chk($sformatf("vec%0d_rt", i), rt_data, vecs[i].exp_rt);
        end
        chk("table_wr_count", {16'h0, wr_count}, 32'd6);

        // debug port: latency, zero index, pre-write value
        dbg_addr = 5'd5;
        @(posedge clk); @(negedge clk);
        chk("dbg_r5", dbg_data, 32'hDEADBEEF);
        dbg_addr = 5'd0;
        @(posedge clk); @(negedge clk);
        chk("dbg_r0", dbg_data, 32'h0);
        dbg_addr = 5'd3;
        do_write(5'd3, 32'h00000002);
        chk("dbg_prewrite", dbg_data, 32'h00000001);
        @(posedge clk); @(negedge clk);
        chk("dbg_postwrite", dbg_data, 32'h00000002);

        // 5: async reset between edges
        do_write(5'd9, 32'hA5A5A5A5);
        rs_addr = 5'd9; dbg_addr = 5'd9; #1;
        chk("r9_written", rs_data, 32'hA5A5A5A5);
        @(posedge clk); #2;
        chk("dbg_r9", dbg_data, 32'hA5A5A5A5);
        rst = 1'b1; #1;
        chk("async_rst_r9", rs_data, 32'h0);
        chk("async_rst_dbg", dbg_data, 32'h0);
        chk("async_rst_wr_count", {16'h0, wr_count}, 32'h0);
        // write held across an edge during reset is lost
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFEF00D;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0; rst = 1'b0; rs_addr = 5'd10; rt_addr = 5'd5; #1;
        chk("rst_write_lost", rs_data, 32'h0);
        chk("rst_r5_cleared", rt_data, 32'h0);
        chk("rst_write_count", {16'h0, wr_count}, 32'h0);

        // 6: saturation of wr_count
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h00000042;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("wr_count_fffe", {16'h0, wr_count}, 32'h0000FFFE);
        do_write(5'd3, 32'h00000001);
        chk("wr_count_ffff", {16'h0, wr_count}, 32'h0000FFFF);
        do_write(5'd4, 32'h00000004);
        do_write(5'd4, 32'h00000005);
        chk("wr_count_sat", {16'h0, wr_count}, 32'h0000FFFF);
        rs_addr = 5'd4; rt_addr = 5'd1; #1;
        chk("sat_write_r4", rs_data, 32'h00000005);
        chk("sat_write_r1", rt_data, 32'h00000042);
        dbg_addr = 5'd3;
        @(posedge clk); @(negedge clk);
        chk("dbg_r3_final", dbg_data, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
